memctrl: RTL and testbench

MEMCTRL -- requirements
Module: memctrl

---
 rtl/memctrl.sv | 144 ++++++++++++++
 tb/tb_memctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl.sv
// memctrl: arbitrates a single-port, byte-wide RAM between MEM-stage byte accesses
// and 4-byte little-endian instruction fetches, with MEM holding strict priority.
module memctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_flag_i,
  output logic        mem_r_o,
  output logic [7:0]  mem_data_o,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // One entry per issued read; tag1 lines up with the cycle its byte is on ram_din_i.
  typedef struct packed {
    logic       valid;
    logic       src_if;
    logic [1:0] k;
  } tag_t;

  state_t      r_state;
  logic [31:0] r_fa;
  logic [2:0]  r_ki;
  logic [2:0]  r_kr;
  logic [23:0] r_ibuf;
  tag_t        r_tag0;
  tag_t        r_tag1;

  logic w_mem_rd;
  logic w_mem_wr;
  logic w_mem_busy;
  logic w_abort;
  logic w_if_issue;
  logic w_if_ret;
  logic w_mem_ret;

  assign w_mem_rd   = (mem_rw_i == 2'b01);
  assign w_mem_wr   = (mem_rw_i == 2'b10);
  assign w_mem_busy = (mem_rw_i != 2'b00) || mem_flag_i;
  assign w_abort    = (r_state != S_IDLE) && (!if_req_i || (if_addr_i != r_fa));
  assign w_if_issue = (r_state == S_ISSUE) && !w_mem_busy && !w_abort;
  assign w_if_ret   = r_tag1.valid && r_tag1.src_if && !w_abort;
  assign w_mem_ret  = r_tag1.valid && !r_tag1.src_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tag pipe is cleared too, so no byte in flight at reset can raise a response.
      r_state    <= S_IDLE;
      r_fa       <= '0;
      r_ki       <= '0;
      r_kr       <= '0;
      r_ibuf     <= '0;
      r_tag0     <= '0;
      r_tag1     <= '0;
      ram_a_o    <= '0;
      ram_wr_o   <= 1'b0;
      ram_dout_o <= '0;
      mem_r_o    <= 1'b0;
      mem_data_o <= '0;
      if_valid_o <= 1'b0;
      if_inst_o  <= '0;
    end else begin
      ram_a_o    <= '0;
      ram_wr_o   <= 1'b0;
      ram_dout_o <= '0;
      mem_r_o    <= 1'b0;
      if_valid_o <= 1'b0;
      r_tag0     <= '0;

      // RAM port: MEM first, then a pending fetch byte.
      if (w_mem_rd) begin
        ram_a_o <= mem_addr_i;
        r_tag0  <= '{valid: 1'b1, src_if: 1'b0, k: 2'd0};
      end else if (w_mem_wr) begin
        ram_a_o    <= mem_addr_i;
        ram_wr_o   <= 1'b1;
        ram_dout_o <= mem_data_i;
      end else if (w_if_issue) begin
        ram_a_o <= r_fa + {29'd0, r_ki};
        r_tag0  <= '{valid: 1'b1, src_if: 1'b1, k: r_ki[1:0]};
      end

      r_tag1 <= r_tag0;
      if (w_abort && r_tag0.src_if)
        r_tag1.valid <= 1'b0;

      if (w_mem_ret) begin
        mem_r_o    <= 1'b1;
        mem_data_o <= ram_din_i;
      end

      if (w_if_ret) begin
        r_kr <= r_kr + 3'd1;
        case (r_tag1.k)
          2'd0: r_ibuf[7:0]   <= ram_din_i;
          2'd1: r_ibuf[15:8]  <= ram_din_i;
          2'd2: r_ibuf[23:16] <= ram_din_i;
          default: begin
            if (r_kr == 3'd3 && r_state == S_WAIT) begin
              if_valid_o <= 1'b1;
              if_inst_o  <= {ram_din_i, r_ibuf};
            end
          end
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (if_req_i && !w_mem_busy) begin
            r_state <= S_ISSUE;
            r_fa    <= if_addr_i;
            r_ki    <= '0;
            r_kr    <= '0;
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_if_issue) begin
            r_ki <= r_ki + 3'd1;
            if (r_ki == 3'd3)
              r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort || (w_if_ret && r_kr == 3'd3))
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed self-checking bench for memctrl, driving a 1-cycle-latency
// byte RAM model whose contents are a fixed lookup table.
module tb_memctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic        mem_flag_i;
  logic        mem_r_o;
  logic [7:0]  mem_data_o;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ifv    = 0;
  int n_memr   = 0;
  int ifv0;
  int memr0;

  memctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rw_i   (mem_rw_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_flag_i (mem_flag_i),
    .mem_r_o    (mem_r_o),
    .mem_data_o (mem_data_o),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_valid_o (if_valid_o),
    .if_inst_o  (if_inst_o),
    .ram_a_o    (ram_a_o),
    .ram_wr_o   (ram_wr_o),
    .ram_dout_o (ram_dout_o),
    .ram_din_i  (ram_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: rom = 8'h13;
      32'h101: rom = 8'h05;
      32'h102: rom = 8'h00;
      32'h103: rom = 8'h00;
      32'h200: rom = 8'h93;
      32'h201: rom = 8'h00;
      32'h202: rom = 8'h10;
      32'h203: rom = 8'h00;
      32'h400: rom = 8'h37;
      32'h401: rom = 8'h12;
      32'h402: rom = 8'h00;
      32'h403: rom = 8'h00;
      32'h1000: rom = 8'hAB;
      32'h20: rom = 8'h11;
      32'h21: rom = 8'h22;
      32'h22: rom = 8'h33;
      32'h23: rom = 8'h44;
      default: rom = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) ram_din_i <= rom(ram_a_o);

  always @(negedge clk) begin
    if (if_valid_o) n_ifv++;
    if (mem_r_o) n_memr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 20 cycles for if_valid_o; checks the latency and the returned word.
  task automatic wait_if_valid(input string tag, input int exp_cycles, input logic [31:0] exp_inst);
    int  n    = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (if_valid_o) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check({tag, " latency"}, n, exp_cycles);
    check({tag, " inst"}, if_inst_o, exp_inst);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    mem_rw_i   = 2'b00;
    mem_addr_i = '0;
    mem_data_i = '0;
    mem_flag_i = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    tick();
    tick();
    check("rst ram_a", ram_a_o, 0);
    check("rst ram_wr", ram_wr_o, 0);
    check("rst if_valid", if_valid_o, 0);
    check("rst mem_r", mem_r_o, 0);
    rst = 1'b0;
    tick();

    // Plain fetch at 0x100.
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    tick();
    check("s1 no issue on start", ram_a_o, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("s1 addr%0d", c), ram_a_o, 32'h100 + c);
      check($sformatf("s1 rd%0d", c), ram_wr_o, 0);
    end
    tick();
    check("s1 early valid", if_valid_o, 0);
    tick();
    check("s1 valid", if_valid_o, 1);
    check("s1 inst", if_inst_o, 32'h00000513);
    if_req_i = 1'b0;
    tick();
    check("s1 valid one cycle", if_valid_o, 0);

    // MEM read interrupts a fetch after two bytes.
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    tick();
    tick();
    check("s2 addr0", ram_a_o, 32'h200);
    tick();
    check("s2 addr1", ram_a_o, 32'h201);
    mem_rw_i   = 2'b01;
    mem_addr_i = 32'h1000;
    tick();
    check("s2 mem addr", ram_a_o, 32'h1000);
    mem_rw_i = 2'b00;
    tick();
    check("s2 resume addr2", ram_a_o, 32'h202);
    tick();
    check("s2 mem_r", mem_r_o, 1);
    check("s2 mem_data", mem_data_o, 8'hAB);
    check("s2 addr3", ram_a_o, 32'h203);
    tick();
    check("s2 mem_r one cycle", mem_r_o, 0);
    check("s2 early valid", if_valid_o, 0);
    tick();
    check("s2 valid", if_valid_o, 1);
    check("s2 inst", if_inst_o, 32'h00100093);
    if_req_i = 1'b0;
    tick();

    // Four back-to-back MEM reads with the port held; a waiting fetch must not issue.
    mem_rw_i   = 2'b01;
    mem_addr_i = 32'h20;
    mem_flag_i = 1'b1;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h100;
    tick();
    check("s3 addr0", ram_a_o, 32'h20);
    mem_addr_i = 32'h21;
    tick();
    check("s3 addr1", ram_a_o, 32'h21);
    mem_addr_i = 32'h22;
    tick();
    check("s3 addr2", ram_a_o, 32'h22);
    check("s3 r0", mem_r_o, 1);
    check("s3 d0", mem_data_o, 8'h11);
    mem_addr_i = 32'h23;
    mem_flag_i = 1'b0;
    tick();
    check("s3 addr3", ram_a_o, 32'h23);
    check("s3 r1", mem_r_o, 1);
    check("s3 d1", mem_data_o, 8'h22);
    mem_rw_i = 2'b00;
    tick();
    check("s3 no if issue", ram_a_o, 0);
    check("s3 r2", mem_r_o, 1);
    check("s3 d2", mem_data_o, 8'h33);
    tick();
    check("s3 if addr0", ram_a_o, 32'h100);
    check("s3 r3", mem_r_o, 1);
    check("s3 d3", mem_data_o, 8'h44);
    tick();
    check("s3 r end", mem_r_o, 0);
    wait_if_valid("s3 fetch", 4, 32'h00000513);
    if_req_i = 1'b0;
    tick();

    // MEM write: one cycle on the RAM port, no response.
    memr0      = n_memr;
    mem_rw_i   = 2'b10;
    mem_addr_i = 32'h30;
    mem_data_i = 8'h5A;
    tick();
    check("s4 wr", ram_wr_o, 1);
    check("s4 addr", ram_a_o, 32'h30);
    check("s4 dout", ram_dout_o, 8'h5A);
    mem_rw_i   = 2'b00;
    mem_data_i = 8'h00;
    tick();
    check("s4 wr one cycle", ram_wr_o, 0);
    check("s4 addr idle", ram_a_o, 0);
    tick();
    tick();
    check("s4 no mem_r", n_memr - memr0, 0);

    // Branch flush after two bytes issued.
    ifv0      = n_ifv;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    tick();
    tick();
    check("s5 addr0", ram_a_o, 32'h100);
    tick();
    check("s5 addr1", ram_a_o, 32'h101);
    if_addr_i = 32'h400;
    tick();
    check("s5 abort no issue", ram_a_o, 0);
    wait_if_valid("s5 refetch", 7, 32'h00001237);
    if_req_i = 1'b0;
    tick();
    check("s5 one valid", n_ifv - ifv0, 1);

    // Synchronous reset in the middle of a fetch.
    ifv0      = n_ifv;
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("s6 ram_a", ram_a_o, 0);
    check("s6 ram_wr", ram_wr_o, 0);
    check("s6 ram_dout", ram_dout_o, 0);
    check("s6 mem_r", mem_r_o, 0);
    check("s6 mem_data", mem_data_o, 0);
    check("s6 if_valid", if_valid_o, 0);
    check("s6 if_inst", if_inst_o, 0);
    rst = 1'b0;
    wait_if_valid("s6 refetch", 7, 32'h00100093);
    if_req_i = 1'b0;
    tick();
    check("s6 one valid", n_ifv - ifv0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
